// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared state encoding and Gray/clog2 helpers for the pixel frame controller
package pixel_pkg;

  typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ, SEND} state_t;

  localparam int MAX_W = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Both conversions are unaffected by zero extension, so callers widen to MAX_W and cast back.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/pixel_frame_buffer.sv
// rtl/pixel_frame_buffer.sv - one-frame pixel store, single write port and asynchronous read port
module pixel_frame_buffer #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_frame_ctrl.sv
// rtl/pixel_frame_ctrl.sv - erase/expose/convert/read sequencer with one-frame AXIS streaming
module pixel_frame_ctrl
  import pixel_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLUMNS   = 4,
  parameter int DATA_W    = 8,
  parameter int ERASE_CYC = 5,
  parameter int READ_CYC  = 5,
  parameter int EXP_W     = 16,
  localparam int PIXELS   = ROWS * COLUMNS,
  localparam int AW       = (clog2(PIXELS) < 1) ? 1 : clog2(PIXELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              cont_mode,
  input  logic              abort,
  input  logic [EXP_W-1:0]  expose_len,
  input  logic              clr_status,
  output logic              erase,
  output logic              expose,
  output logic              ramp_en,
  output logic              read,
  output logic [AW-1:0]     pixel_addr,
  output logic [DATA_W-1:0] adc_code,
  input  logic [DATA_W-1:0] pixel_data,
  output logic              tvalid,
  input  logic              tready,
  output logic [DATA_W-1:0] tdata,
  output logic              tlast,
  output logic              tuser,
  output logic              busy,
  output logic              overrun,
  output logic [15:0]       frame_cnt
);

  localparam logic [31:0] ERASE_LAST = 32'(ERASE_CYC - 1);
  localparam logic [31:0] READ_LAST  = 32'(READ_CYC - 1);
  localparam logic [31:0] RAMP_LAST  = 32'((1 << DATA_W) - 1);
  localparam logic [AW-1:0] PIX_LAST = AW'(PIXELS - 1);

  state_t             state, state_n;
  logic [31:0]        cnt, cnt_n;
  logic [AW-1:0]      pix, pix_n;
  logic [EXP_W-1:0]   exp_len, exp_n;
  logic [15:0]        fc_n;
  logic               ovr_n;
  logic [31:0]        exp_wide;
  logic [EXP_W-1:0]   exp_in;
  logic               wr_en;
  logic [DATA_W-1:0]  wr_data;
  logic [DATA_W-1:0]  rd_data;

  assign exp_wide = 32'(exp_len);
  assign exp_in   = (expose_len == '0) ? EXP_W'(1) : expose_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pix       <= '0;
      exp_len   <= '0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
      adc_code  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pix       <= pix_n;
      exp_len   <= exp_n;
      frame_cnt <= fc_n;
      overrun   <= ovr_n;
      // Registered from the next count so adc_code lines up with ramp_en cycle by cycle.
      adc_code  <= (state_n == CONVERT) ? DATA_W'(bin2gray(MAX_W'(cnt_n))) : '0;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 32'd1;
    pix_n   = pix;
    exp_n   = exp_len;
    fc_n    = frame_cnt;
    ovr_n   = overrun;
    if (clr_status) ovr_n = 1'b0;
    if (trigger && state != IDLE) ovr_n = 1'b1;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (trigger) begin
          state_n = ERASE;
          exp_n   = exp_in;
        end
      end
      ERASE: begin
        if (cnt == ERASE_LAST) begin
          state_n = EXPOSE;
          cnt_n   = '0;
        end
      end
      EXPOSE: begin
        if (cnt == exp_wide - 32'd1) begin
          state_n = CONVERT;
          cnt_n   = '0;
        end
      end
      CONVERT: begin
        if (cnt == RAMP_LAST) begin
          state_n = READ;
          cnt_n   = '0;
          pix_n   = '0;
        end
      end
      READ: begin
        if (cnt == READ_LAST) begin
          cnt_n = '0;
          if (pix == PIX_LAST) begin
            state_n = SEND;
            pix_n   = '0;
          end else begin
            pix_n = pix + 1'b1;
          end
        end
      end
      SEND: begin
        cnt_n = '0;
        if (tready) begin
          if (pix == PIX_LAST) begin
            pix_n = '0;
            fc_n  = frame_cnt + 16'd1;
            if (cont_mode) begin
              state_n = ERASE;
              exp_n   = exp_in;
            end else begin
              state_n = IDLE;
            end
          end else begin
            pix_n = pix + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Abort never reaches SEND, so a stream that has started always completes.
    if (abort && (state == ERASE || state == EXPOSE || state == CONVERT || state == READ)) begin
      state_n = IDLE;
      cnt_n   = '0;
      pix_n   = '0;
    end
  end

  assign wr_en   = (state == READ) && (cnt == READ_LAST);
  assign wr_data = DATA_W'(gray2bin(MAX_W'(pixel_data)));

  pixel_frame_buffer #(
    .DEPTH (PIXELS),
    .W     (DATA_W),
    .AW    (AW)
  ) u_buffer (
    .clk   (clk),
    .we    (wr_en),
    .waddr (pix),
    .wdata (wr_data),
    .raddr (pix),
    .rdata (rd_data)
  );

  assign erase      = (state == ERASE);
  assign expose     = (state == EXPOSE);
  assign ramp_en    = (state == CONVERT);
  assign read       = (state == READ);
  assign pixel_addr = (state == READ) ? pix : '0;
  assign busy       = (state != IDLE);
  assign tvalid     = (state == SEND);
  assign tdata      = (state == SEND) ? rd_data : '0;
  assign tuser      = (state == SEND) && (pix == '0);
  assign tlast      = (state == SEND) && (pix == PIX_LAST);

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// tb/tb_pixel_frame_ctrl.sv - randomized self-checking bench against a frame-level reference model
module tb_pixel_frame_ctrl;

  localparam int ROWS = 2, COLUMNS = 2, DATA_W = 4, ERASE_CYC = 3, READ_CYC = 2, EXP_W = 16;
  localparam int PIXELS = ROWS * COLUMNS;
  localparam int RAMP   = 1 << DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic trigger, cont_mode, abort, clr_status, tready;
  logic [EXP_W-1:0] expose_len;
  logic erase, expose, ramp_en, read, tvalid, tlast, tuser, busy, overrun;
  logic [1:0] pixel_addr;
  logic [DATA_W-1:0] adc_code, pixel_data, tdata;
  logic [15:0] frame_cnt;

  logic [DATA_W-1:0] pix_val [PIXELS];
  logic [DATA_W-1:0] sel_val;
  logic [DATA_W-1:0] junk;

  // Array model: presents the Gray code of the stored pixel value while read is high.
  assign sel_val    = pix_val[pixel_addr];
  assign pixel_data = read ? (sel_val ^ (sel_val >> 1)) : junk;

  always #5 clk = ~clk;

  pixel_frame_ctrl #(
    .ROWS(ROWS), .COLUMNS(COLUMNS), .DATA_W(DATA_W),
    .ERASE_CYC(ERASE_CYC), .READ_CYC(READ_CYC), .EXP_W(EXP_W)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .cont_mode(cont_mode), .abort(abort),
    .expose_len(expose_len), .clr_status(clr_status), .erase(erase), .expose(expose),
    .ramp_en(ramp_en), .read(read), .pixel_addr(pixel_addr), .adc_code(adc_code),
    .pixel_data(pixel_data), .tvalid(tvalid), .tready(tready), .tdata(tdata),
    .tlast(tlast), .tuser(tuser), .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_erase, n_expose, n_ramp, n_read, n_runs, n_valid;
  int n_onehot_err, n_ramp_err, n_stall_err, n_gap_err;
  logic [DATA_W+1:0] beats [$];
  logic [15:0] exp_fc = 16'd0;
  logic exp_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-cycle observer and stimulus driver; tmode 0=ready, 1=random, 2=held low.
  task automatic watch(input int tmode, input int mode, input int stop_frames, input int budget);
    int cyc = 0;
    int ramp_idx = 0;
    bit seen_busy = 0, done = 0, inj = 0, chk_abort = 0;
    bit prev_erase = 0, prev_v = 0, prev_r = 0, prev_last_cont = 0;
    logic [DATA_W+1:0] prev_beat = '0;
    logic [DATA_W+1:0] cur;
    n_erase = 0; n_expose = 0; n_ramp = 0; n_read = 0; n_runs = 0; n_valid = 0;
    n_onehot_err = 0; n_ramp_err = 0; n_stall_err = 0; n_gap_err = 0;
    beats.delete();
    while (!done) begin
      @(negedge clk);
      cyc++;
      trigger = 1'b0; clr_status = 1'b0; abort = 1'b0;
      case (tmode)
        0: tready = 1'b1;
        1: tready = 1'($urandom_range(0, 1));
        default: tready = 1'b0;
      endcase
      if (chk_abort) begin
        check("abort_idle", {26'd0, busy, erase, expose, ramp_en, read, tvalid}, 32'd0);
        chk_abort = 0;
      end
      if ($countones({erase, expose, ramp_en, read}) > 1) n_onehot_err++;
      if (erase) n_erase++;
      if (erase && !prev_erase) n_runs++;
      if (expose) n_expose++;
      if (read) n_read++;
      if (ramp_en) begin
        if (adc_code != DATA_W'(ramp_idx ^ (ramp_idx >> 1))) n_ramp_err++;
        ramp_idx++;
        n_ramp++;
      end else begin
        ramp_idx = 0;
        if (adc_code != '0) n_ramp_err++;
      end
      if (prev_last_cont && !erase) n_gap_err++;
      prev_last_cont = 0;
      cur = {tuser, tlast, tdata};
      if (tvalid) begin
        n_valid++;
        if (prev_v && !prev_r && cur !== prev_beat) n_stall_err++;
      end
      if (tvalid && tready) begin
        beats.push_back(cur);
        if (tlast && cont_mode) prev_last_cont = 1;
      end
      prev_v = tvalid; prev_r = tready; prev_beat = cur; prev_erase = erase;
      if (busy) seen_busy = 1;
      if (!inj) begin
        case (mode)
          1: if (expose) begin trigger = 1'b1; inj = 1; end
          2: if (expose) begin trigger = 1'b1; clr_status = 1'b1; inj = 1; end
          3: if (ramp_en && ramp_idx == 6) begin abort = 1'b1; inj = 1; chk_abort = 1; end
          4: if (tvalid) begin abort = 1'b1; inj = 1; end
          5: if (tvalid) begin
               inj = 1;
               #1 rst = 1'b0;
               #1 check("rst_async", {28'd0, tvalid, tlast, tuser, busy}, 32'd0);
               @(negedge clk);
               rst = 1'b1;
               done = 1;
             end
          default: ;
        endcase
      end
      if (stop_frames > 0 && n_runs >= stop_frames) cont_mode = 1'b0;
      if (seen_busy && !busy) done = 1;
      if (!done && cyc >= budget) begin
        check("timeout", 32'(cyc), 32'(budget - 1));
        done = 1;
      end
    end
    trigger = 1'b0; clr_status = 1'b0; abort = 1'b0;
  endtask

  task automatic run_frame(input logic [EXP_W-1:0] elen, input int tmode, input int mode,
                           input bit cont, input int nframes);
    int exp_cyc;
    int k;
    exp_cyc = (elen == 0) ? 1 : int'(elen);
    expose_len = elen;
    cont_mode  = cont;
    @(negedge clk);
    trigger = 1'b1;
    watch(tmode, mode, cont ? nframes : 0, 4000);
    cont_mode = 1'b0;
    if (mode == 1 || mode == 2) exp_ovr = 1'b1;
    if (mode == 3) begin
      check("abort_beats", 32'(beats.size()), 32'd0);
      check("abort_tvalid", 32'(n_valid), 32'd0);
      check("abort_fc", {16'd0, frame_cnt}, {16'd0, exp_fc});
    end else if (mode == 5) begin
      exp_fc  = 16'd0;
      exp_ovr = 1'b0;
      check("rst_fc", {16'd0, frame_cnt}, 32'd0);
    end else begin
      exp_fc = exp_fc + 16'(nframes);
      check("erase_cycles", 32'(n_erase), 32'(nframes * ERASE_CYC));
      check("erase_runs", 32'(n_runs), 32'(nframes));
      check("expose_cycles", 32'(n_expose), 32'(nframes * exp_cyc));
      check("ramp_cycles", 32'(n_ramp), 32'(nframes * RAMP));
      check("read_cycles", 32'(n_read), 32'(nframes * PIXELS * READ_CYC));
      check("beat_count", 32'(beats.size()), 32'(nframes * PIXELS));
      for (int i = 0; i < beats.size() && i < nframes * PIXELS; i++) begin
        k = i % PIXELS;
        check($sformatf("beat%0d", i), 32'(beats[i]), 32'({k == 0, k == PIXELS - 1, pix_val[k]}));
      end
      check("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_fc});
      check("busy_end", {31'd0, busy}, 32'd0);
      check("seq_errors", 32'(n_onehot_err + n_ramp_err + n_stall_err + n_gap_err), 32'd0);
    end
    check("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
  endtask

  task automatic load_pixels(input bit rnd, input int a, input int b, input int c, input int d);
    int t [PIXELS];
    t = '{a, b, c, d};
    for (int i = 0; i < PIXELS; i++) pix_val[i] = rnd ? DATA_W'($urandom) : DATA_W'(t[i]);
  endtask

  initial begin
    trigger = 1'b0; cont_mode = 1'b0; abort = 1'b0; clr_status = 1'b0; tready = 1'b1;
    expose_len = '0;
    junk = DATA_W'($urandom);
    load_pixels(0, 5, 9, 0, 15);
    repeat (3) @(negedge clk);
    check("rst_ctrl", {28'd0, erase, expose, ramp_en, read}, 32'd0);
    check("rst_addr", {30'd0, pixel_addr}, 32'd0);
    check("rst_adc", {28'd0, adc_code}, 32'd0);
    check("rst_axis", {25'd0, tvalid, tlast, tuser, tdata}, 32'd0);
    check("rst_status", {14'd0, busy, overrun, frame_cnt}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_frame(16'd10, 0, 0, 0, 1);
    run_frame(16'd10, 1, 0, 0, 1);
    load_pixels(1, 0, 0, 0, 0);
    run_frame(16'd4, 1, 0, 1, 3);

    run_frame(16'd6, 0, 1, 0, 1);
    @(negedge clk); clr_status = 1'b1;
    @(negedge clk); clr_status = 1'b0;
    exp_ovr = 1'b0;
    check("ovr_cleared", {31'd0, overrun}, 32'd0);
    run_frame(16'd6, 1, 2, 0, 1);

    run_frame(16'd3, 0, 3, 0, 1);
    load_pixels(1, 0, 0, 0, 0);
    run_frame(16'd3, 1, 4, 0, 1);

    for (int f = 0; f < 3; f++) begin
      load_pixels(1, 0, 0, 0, 0);
      run_frame(EXP_W'($urandom_range(1, 20)), int'($urandom_range(0, 1)), 0, 0, 1);
    end

    run_frame(16'd2, 2, 5, 0, 1);
    load_pixels(1, 0, 0, 0, 0);
    run_frame(16'd0, 1, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_frame_ctrl.md
Name: pixel_frame_ctrl

Overview:
Parametrised next-generation controller for the pixel array: sequences erase, expose, ramp-convert and per-pixel read, buffers one frame, and streams it over AXI4-Stream with correct backpressure handling. It adds generic ADC width, run-time exposure length, single-shot/continuous modes, start-of-frame marking, abort, frame counting and an overrun flag. It sits between the analog pixel array model/macro and the downstream AXIS consumer.

Parameters:
ROWS, 4, pixel rows
COLUMNS, 4, pixel columns
DATA_W, 8, ADC code width; the ramp lasts 2**DATA_W cycles
ERASE_CYC, 5, erase duration in cycles (>=1)
READ_CYC, 5, cycles each pixel address is held (>=1)
EXP_W, 16, width of the exposure length input

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
trigger  in  1  start frame (sampled in IDLE)
cont_mode  in  1  1 = restart capture automatically after each frame
abort  in  1  return to IDLE (honoured in ERASE..READ only)
expose_len  in  EXP_W  exposure cycles, latched on frame start
clr_status  in  1  clear overrun flag
erase  out  1  pixel erase
expose  out  1  expose enable (array bias clocking)
ramp_en  out  1  ramp/convert enable
read  out  1  array drives pixel_data when high
pixel_addr  out  clog2(ROWS*COLUMNS)  pixel select
adc_code  out  DATA_W  Gray-coded ramp count to array
pixel_data  in  DATA_W  Gray code read from the selected pixel
tvalid  out  1  AXIS valid
tready  in  1  AXIS ready
tdata  out  DATA_W  binary pixel value
tlast  out  1  last pixel of frame
tuser  out  1  first pixel of frame (SOF)
busy  out  1  state != IDLE
overrun  out  1  sticky: trigger arrived while busy
frame_cnt  out  16  completed frames, wraps

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; counters 0. Frame buffer contents are undefined after reset.
- PIXELS = ROWS*COLUMNS; pixel index = row*COLUMNS+col.
- IDLE: trigger=1 -> ERASE on the next edge. Latch expose_len at this edge; expose_len=0 is treated as 1.
- ERASE: erase=1 for exactly ERASE_CYC cycles -> EXPOSE.
- EXPOSE: expose=1 for exactly the latched number of cycles -> CONVERT.
- CONVERT:
  - ramp_en=1 for 2**DATA_W cycles.
  - Binary counter q runs 0..2**DATA_W-1.
  - adc_code = q ^ (q>>1), registered.
  - adc_code=0 outside CONVERT.
- READ:
  - read=1.
  - pixel_addr steps 0..PIXELS-1, each held READ_CYC cycles.
  - pixel_data is sampled on the last cycle of each hold.
  - buffer[addr] = gray2bin(pixel_data).
  - After the last sample -> SEND.
- SEND (AXIS rules):
  - tvalid=1 from the first SEND cycle.
  - A beat transfers when tvalid&&tready.
  - tdata/tlast/tuser are stable while tvalid&&!tready.
  - Beat k carries buffer[k].
  - tuser=1 on k=0 only; tlast=1 on k=PIXELS-1 only.
  - tready held low stalls indefinitely with no data loss.
  - On the last transfer: frame_cnt += 1 (wraps 0xFFFF->0). Then, if cont_mode=1 -> ERASE (expose_len re-latched), else IDLE.
  - The only bubble between frames in continuous mode is the capture time.
- abort=1 in ERASE/EXPOSE/CONVERT/READ: next state IDLE; erase/expose/ramp_en/read drop next cycle; frame_cnt unchanged. abort is ignored in IDLE and SEND; a started stream always completes.
- trigger while busy: ignored and sets overrun. If set and clr_status coincide, set wins.
- trigger in IDLE while cont_mode=1: starts the continuous loop; clearing cont_mode stops after the current frame.
- At most one of erase/expose/ramp_en/read is high in any cycle.
- Gray decode: b[DATA_W-1]=g[DATA_W-1]; b[i]=b[i+1]^g[i].

Decomposition:
- Package pixel_pkg: state enum (IDLE, ERASE, EXPOSE, CONVERT, READ, SEND), functions bin2gray/gray2bin parametrised on width, clog2 helper.
- Sub-module pixel_frame_buffer: PIXELS x DATA_W, one write port (READ) and one read port (SEND). It is the natural candidate for later RAM mapping.

Test Plan:
1. ROWS=COLUMNS=2, DATA_W=4, ERASE_CYC=3, READ_CYC=2, expose_len=10, tready=1, array returns gray(5),gray(9),gray(0),gray(15) -> erase high 3 cycles, expose 10, ramp_en 16; stream 5,9,0,15 with tuser on beat 0, tlast on beat 3; frame_cnt=1; busy falls.
2. Same frame, tready toggles 1,0,0,1,0,1... -> exactly 4 beats; tdata stable during stalls; no duplicates or drops.
3. cont_mode=1, one trigger pulse -> 3 back-to-back frames, each starting with erase after tlast; clear cont_mode during frame 3 -> IDLE after frame 3, frame_cnt=3.
4. trigger pulsed during EXPOSE -> overrun=1, frame unaffected; clr_status -> overrun=0; trigger and clr_status in the same cycle while busy -> overrun=1.
5. abort during CONVERT -> IDLE next cycle, all array controls 0, tvalid never asserted, frame_cnt unchanged; abort during SEND -> ignored, full frame delivered.
6. rst asserted mid-SEND with tready=0 -> tvalid/tlast/tuser/busy 0 immediately (asynchronous); after release a new trigger produces a correct 4-beat frame; expose_len=0 gives a 1-cycle expose.
